// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Holds the state encoding, coin values, product codes and price lookup.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int COIN5_VAL  = 5;
    localparam int COIN10_VAL = 10;

    localparam logic [1:0] PROD0 = 2'd0;
    localparam logic [1:0] PROD1 = 2'd1;
    localparam logic [1:0] PROD2 = 2'd2;
    localparam logic [1:0] PROD3 = 2'd3;

    // Prices stay module parameters; the package only maps code to price.
    function automatic int price_of(
        input logic [1:0] code,
        input int         p0,
        input int         p1,
        input int         p2,
        input int         p3
    );
        int p;
        p = p0;
        unique case (code)
            PROD0: p = p0;
            PROD1: p = p1;
            PROD2: p = p2;
            PROD3: p = p3;
            default: p = p0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter for the COLLECT state.
// Ports: clk, rst (sync, active-high), clear, enable, expired (count hit LIMIT-1).
module vend_timeout_ctr #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(LIMIT - 1));

    // Saturates at the limit so the count never wraps while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, product selection,
// dispense handshake and change-return handshake.
// Inputs : clk, rst (sync, active-high), coin_5, coin_10, sel_valid,
//          sel_product, cancel, dispense_ready, change_ready.
// Outputs: credit, dispense_valid, dispense_product, change_valid,
//          change_amt, coin_reject, sel_nack, busy.
// Optional: define VEND_TIMEOUT_EN to refund after TIMEOUT_CYCLES idle
//           cycles in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W       = 6,
    parameter int MAX_CREDIT     = 40,
    parameter int PRICE0         = 5,
    parameter int PRICE1         = 10,
    parameter int PRICE2         = 15,
    parameter int PRICE3         = 20,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                sel_valid,
    input  logic [1:0]          sel_product,
    input  logic                cancel,
    input  logic                dispense_ready,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_valid,
    output logic [1:0]          dispense_product,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                sel_nack,
    output logic                busy
);

    // Two spare bits keep credit + coins free of overflow.
    localparam int AW = CREDIT_W + 2;

    if (MAX_CREDIT >= 2 ** CREDIT_W || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("vend_controller: bad CREDIT_W/MAX_CREDIT/TIMEOUT_CYCLES");
    end

    state_t              state;
    state_t              state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [CREDIT_W-1:0] change_nx;
    logic [1:0]          prod_nx;
    logic                reject_nx;
    logic                nack_nx;
    logic [AW-1:0]       coin_val;
    logic [AW-1:0]       price;
    logic [AW-1:0]       max_c;
    logic [AW-1:0]       work;
    logic                timeout;

    assign coin_val = (coin_5  ? AW'(COIN5_VAL)  : '0)
                    + (coin_10 ? AW'(COIN10_VAL) : '0);
    assign price    = AW'(price_of(sel_product, PRICE0, PRICE1,
                                   PRICE2, PRICE3));
    assign max_c    = AW'(MAX_CREDIT);

`ifdef VEND_TIMEOUT_EN
    logic activity;
    logic expired;

    assign activity = coin_5 | coin_10 | sel_valid | cancel;

    // Held clear outside COLLECT, so it starts from 0 on entry.
    vend_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state != COLLECT) | activity),
        .enable  (state == COLLECT),
        .expired (expired)
    );

    assign timeout = expired & (state == COLLECT);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        credit_nx = credit;
        change_nx = change_amt;
        prod_nx   = dispense_product;
        reject_nx = 1'b0;
        nack_nx   = 1'b0;
        work      = '0;
        unique case (state)
            IDLE: begin
                // Credit is zero here, so any selection is refused.
                nack_nx = sel_valid;
                if (coin_val != '0) begin
                    if (coin_val <= max_c) begin
                        credit_nx = coin_val[CREDIT_W-1:0];
                        state_nx  = COLLECT;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel || timeout) begin
                    change_nx = credit;
                    credit_nx = '0;
                    state_nx  = CHANGE;
                    reject_nx = (coin_val != '0);
                end else begin
                    // Price is judged on the old credit; a same-cycle
                    // coin lands on top of what is left.
                    work = AW'(credit);
                    if (sel_valid) begin
                        if (work >= price) begin
                            work     = work - price;
                            prod_nx  = sel_product;
                            state_nx = VEND;
                        end else begin
                            nack_nx = 1'b1;
                        end
                    end
                    if (coin_val != '0) begin
                        if (work + coin_val <= max_c) begin
                            work = work + coin_val;
                        end else begin
                            reject_nx = 1'b1;
                        end
                    end
                    credit_nx = work[CREDIT_W-1:0];
                end
            end
            VEND: begin
                reject_nx = (coin_val != '0);
                nack_nx   = sel_valid;
                if (dispense_ready) begin
                    if (credit != '0) begin
                        change_nx = credit;
                        credit_nx = '0;
                        state_nx  = CHANGE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            CHANGE: begin
                reject_nx = (coin_val != '0);
                nack_nx   = sel_valid;
                if (change_ready) begin
                    change_nx = '0;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            credit           <= '0;
            change_amt       <= '0;
            dispense_product <= '0;
            coin_reject      <= 1'b0;
            sel_nack         <= 1'b0;
        end else begin
            state            <= state_nx;
            credit           <= credit_nx;
            change_amt       <= change_nx;
            dispense_product <= prod_nx;
            coin_reject      <= reject_nx;
            sel_nack         <= nack_nx;
        end
    end

    assign dispense_valid = (state == VEND);
    assign change_valid   = (state == CHANGE);
    assign busy           = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_vend_controller;

    localparam int CW   = 6;
    localparam int MAXC = 40;
    localparam int TO   = 8;

    localparam int S_IDLE = 0;
    localparam int S_COLL = 1;
    localparam int S_VEND = 2;
    localparam int S_CHG  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          coin_5 = 1'b0;
    logic          coin_10 = 1'b0;
    logic          sel_valid = 1'b0;
    logic [1:0]    sel_product = 2'd0;
    logic          cancel = 1'b0;
    logic          dispense_ready = 1'b0;
    logic          change_ready = 1'b0;
    logic [CW-1:0] credit;
    logic          dispense_valid;
    logic [1:0]    dispense_product;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic          coin_reject;
    logic          sel_nack;
    logic          busy;

    vend_controller #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .coin_5           (coin_5),
        .coin_10          (coin_10),
        .sel_valid        (sel_valid),
        .sel_product      (sel_product),
        .cancel           (cancel),
        .dispense_ready   (dispense_ready),
        .change_ready     (change_ready),
        .credit           (credit),
        .dispense_valid   (dispense_valid),
        .dispense_product (dispense_product),
        .change_valid     (change_valid),
        .change_amt       (change_amt),
        .coin_reject      (coin_reject),
        .sel_nack         (sel_nack),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int prices[4] = '{5, 10, 15, 20};

    // reference model
    int ms, mcred, mchg, mprod, mrej, mnack, mtc;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; mcred = 0; mchg = 0; mprod = 0;
        mrej = 0; mnack = 0; mtc = 0;
    endtask

    task automatic model_step(input bit c5, input bit c10, input bit sv,
                              input int sp, input bit cn,
                              input bit dr, input bit cr);
        int  cv;
        int  c;
        int  nst;
        bit  to;
        cv = (c5 ? 5 : 0) + (c10 ? 10 : 0);
        to = 1'b0;
`ifdef VEND_TIMEOUT_EN
        to = (ms == S_COLL) && (mtc == TO - 1);
        if (ms != S_COLL || c5 || c10 || sv || cn) mtc = 0;
        else mtc = mtc + 1;
`endif
        mrej = 0; mnack = 0; nst = ms;
        case (ms)
            S_IDLE: begin
                mnack = sv;
                if (cv > 0) begin
                    if (cv <= MAXC) begin mcred = cv; nst = S_COLL; end
                    else mrej = 1;
                end
            end
            S_COLL: begin
                if (cn || to) begin
                    mchg = mcred; mcred = 0; nst = S_CHG;
                    mrej = (cv > 0);
                end else begin
                    c = mcred;
                    if (sv) begin
                        if (c >= prices[sp]) begin
                            c = c - prices[sp]; mprod = sp; nst = S_VEND;
                        end else mnack = 1;
                    end
                    if (cv > 0) begin
                        if (c + cv <= MAXC) c = c + cv;
                        else mrej = 1;
                    end
                    mcred = c;
                end
            end
            S_VEND: begin
                mrej = (cv > 0); mnack = sv;
                if (dr) begin
                    if (mcred > 0) begin
                        mchg = mcred; mcred = 0; nst = S_CHG;
                    end else nst = S_IDLE;
                end
            end
            default: begin
                mrej = (cv > 0); mnack = sv;
                if (cr) begin mchg = 0; nst = S_IDLE; end
            end
        endcase
        ms = nst;
    endtask

    task automatic compare_all();
        check("credit", int'(credit), mcred);
        check("disp_valid", int'(dispense_valid), int'(ms == S_VEND));
        check("disp_prod", int'(dispense_product), mprod);
        check("chg_valid", int'(change_valid), int'(ms == S_CHG));
        check("chg_amt", int'(change_amt), mchg);
        check("coin_reject", int'(coin_reject), mrej);
        check("sel_nack", int'(sel_nack), mnack);
        check("busy", int'(busy), int'(ms == S_VEND || ms == S_CHG));
    endtask

    task automatic step(input bit c5, input bit c10, input bit sv,
                        input int sp, input bit cn,
                        input bit dr, input bit cr);
        @(negedge clk);
        coin_5 = c5; coin_10 = c10; sel_valid = sv;
        sel_product = sp[1:0]; cancel = cn;
        dispense_ready = dr; change_ready = cr;
        model_step(c5, c10, sv, sp, cn, dr, cr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        coin_5 = 0; coin_10 = 0; sel_valid = 0; cancel = 0;
        dispense_ready = 0; change_ready = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    int vcnt;

    initial begin
        model_reset();
        do_reset();
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);

        // 5 + 10, buy product 2, dispenser ready
        step(1, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 2, 0, 1, 0);
        check("t1_dv", int'(dispense_valid), 1);
        check("t1_prod", int'(dispense_product), 2);
        check("t1_credit", int'(credit), 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t1_dv_off", int'(dispense_valid), 0);
        check("t1_no_chg", int'(change_valid), 0);

        // 10 + 10, buy product 0, dispenser late by 3 cycles
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        vcnt = int'(dispense_valid);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            vcnt += int'(dispense_valid);
        end
        check("t2_dv_cycles", vcnt, 4);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_cv", int'(change_valid), 1);
        check("t2_amt", int'(change_amt), 15);
        idle(2);
        check("t2_amt_hold", int'(change_amt), 15);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t2_amt_clr", int'(change_amt), 0);

        // insufficient credit then cancel
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        check("t3_nack", int'(sel_nack), 1);
        check("t3_credit", int'(credit), 10);
        step(0, 0, 0, 0, 1, 0, 0);
        check("t3_amt", int'(change_amt), 10);
        step(0, 0, 0, 0, 0, 0, 1);

        // ceiling
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("t4_rej10", int'(coin_reject), 1);
        check("t4_c35a", int'(credit), 35);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t4_rej15", int'(coin_reject), 1);
        check("t4_c35b", int'(credit), 35);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t4_c40", int'(credit), 40);
        check("t4_norej", int'(coin_reject), 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // coin in VEND, then reset mid-handshake
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t5_rej", int'(coin_reject), 1);
        check("t5_credit", int'(credit), 10);
        do_reset();
        check("t5_rst_dv", int'(dispense_valid), 0);
        check("t5_rst_credit", int'(credit), 0);

        // inactivity in COLLECT
        step(1, 0, 0, 0, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
        idle(TO);
        check("t6_to_cv", int'(change_valid), 1);
        check("t6_to_amt", int'(change_amt), 5);
`else
        idle(20);
        check("t6_hold", int'(credit), 5);
        step(0, 0, 0, 0, 1, 0, 0);
`endif
        step(0, 0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit c5, c10, sv, cn, dr, cr;
            int sp;
            c5 = ($urandom_range(0, 3) == 0);
            c10 = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 5) == 0);
            sp = $urandom_range(0, 3);
            cn = ($urandom_range(0, 15) == 0);
            if (cn) begin c5 = 0; c10 = 0; sv = 0; end
            dr = $urandom_range(0, 1);
            cr = $urandom_range(0, 1);
            step(c5, c10, sv, sp, cn, dr, cr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
